// File: rtl/spart_bus_arb.sv
// spart_bus_arb
//   Shares one SPART register bus between NUM_REQ requesters. Requesters are
//   granted round-robin, and each grant performs exactly one register access.
//   Receive-data reads wait for rda and transmit-data writes wait for tbr, so
//   requesters never have to poll status themselves. When STALL_MAX is
//   nonzero, a wait longer than STALL_MAX cycles aborts the access.
//
//   Optional build macro: SPART_ARB_BAUD_PROTECT_EN
//     When defined, only requester 0 may write the baud divisor registers
//     (addr 10/11). Such a write from any other requester is aborted without
//     a bus cycle and returns err=1.
//
//   Ports
//     clk, rst          system clock, asynchronous active-high reset
//     req               per-requester request level, held until ack
//     req_rw            per-requester direction (1=read, 0=write)
//     req_addr          2 bits per requester, SPART register select
//     req_wdata         8 bits per requester, write data
//     ack               one-cycle completion pulse to the granted requester
//     err               valid with ack; 1 = aborted, no bus cycle performed
//     rdata             read data, valid with ack for reads, held otherwise
//     busy              arbiter is not idle
//     iocs/iorw/ioaddr  SPART bus control
//     databus           SPART data bus; driven only during write accesses
//     rda, tbr          SPART receive-available / transmit-ready status
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for a request; latches winner and its fields
//   CHECK  | waiting for rda/tbr as required; counts stall cycles
//   ACCESS | single bus cycle (iocs=1); read data captured at its end
//   DONE   | ack to winner, err reported, round-robin pointer advanced

module spart_bus_arb #(
  parameter int NUM_REQ   = 2,
  parameter int STALL_MAX = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [2*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 iocs,
  output logic                 iorw,
  output logic [1:0]           ioaddr,
  inout  wire  [7:0]           databus,
  input  logic                 rda,
  input  logic                 tbr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  // The abort fires on the not-ready cycle whose count reaches STALL_MAX.
  localparam logic [SW-1:0] STALL_LAST = SW'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   win_q, win_d;
  logic            rw_q, rw_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;

  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic            sel_rw;
  logic [1:0]      sel_addr;
  logic [7:0]      sel_wdata;
  logic            protect;
  logic            ready;

  // Round-robin pick: scanning offsets from high to low lets the smallest
  // offset from rr_q win without needing an early exit from the loop.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_q) + k) % NUM_REQ]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  assign sel_rw    = req_rw[sel_idx];
  assign sel_addr  = req_addr[2*int'(sel_idx) +: 2];
  assign sel_wdata = req_wdata[8*int'(sel_idx) +: 8];

`ifdef SPART_ARB_BAUD_PROTECT_EN
  assign protect = (sel_idx != '0) && !sel_rw && sel_addr[1];
`else
  assign protect = 1'b0;
`endif

  // Only the data register depends on SPART buffer status.
  assign ready = (addr_q != 2'b00) ? 1'b1 : (rw_q ? rda : tbr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      win_q   <= '0;
      rw_q    <= 1'b1;
      addr_q  <= 2'b00;
      wdata_q <= 8'h00;
      stall_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    stall_d = stall_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          win_d   = sel_idx;
          rw_d    = sel_rw;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          stall_d = '0;
          if (protect) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (ready) begin
          state_d = S_ACCESS;
        end else begin
          stall_d = stall_q + 1'b1;
          if ((STALL_MAX != 0) && (stall_q == STALL_LAST)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_ACCESS: begin
        if (rw_q) begin
          rdata_d = databus;
        end
        err_d   = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        rr_d    = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus outputs decode only from registered state and latched fields, so
  // request inputs never reach the SPART pins combinationally.
  assign iocs    = (state_q == S_ACCESS);
  assign iorw    = iocs ? rw_q : 1'b1;
  assign ioaddr  = iocs ? addr_q : 2'b00;
  assign databus = (iocs && !rw_q) ? wdata_q : 8'hzz;

  always_comb begin
    ack = '0;
    if (state_q == S_DONE) begin
      ack[win_q] = 1'b1;
    end
  end

  assign err   = (state_q == S_DONE) && err_q;
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_spart_bus_arb.sv
// tb_spart_bus_arb
//   Directed scenarios followed by randomized requesters and SPART status.
//   A transaction-level reference model predicts every output each cycle.
//   A second instance with STALL_MAX=8 covers the stall abort.

module tb_spart_bus_arb;

  localparam int N     = 2;
  localparam int STALL = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req, req_rw;
  logic [2*N-1:0]   req_addr;
  logic [8*N-1:0]   req_wdata;
  logic [N-1:0]     ack;
  logic             err, busy, iocs, iorw;
  logic [7:0]       rdata;
  logic [1:0]       ioaddr;
  wire  [7:0]       databus;
  logic             rda, tbr;
  logic [7:0]       spart_data;

  assign databus = (iocs && iorw) ? spart_data : 8'hzz;

  spart_bus_arb #(.NUM_REQ(N), .STALL_MAX(STALL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rda(rda), .tbr(tbr)
  );

  logic [N-1:0]     req8, req_rw8, ack8;
  logic [2*N-1:0]   req_addr8;
  logic [8*N-1:0]   req_wdata8;
  logic             err8, busy8, iocs8, iorw8, rda8, tbr8;
  logic [7:0]       rdata8;
  logic [1:0]       ioaddr8;
  wire  [7:0]       databus8;

  assign databus8 = (iocs8 && iorw8) ? 8'h00 : 8'hzz;

  spart_bus_arb #(.NUM_REQ(N), .STALL_MAX(8)) dut8 (
    .clk(clk), .rst(rst), .req(req8), .req_rw(req_rw8), .req_addr(req_addr8),
    .req_wdata(req_wdata8), .ack(ack8), .err(err8), .rdata(rdata8), .busy(busy8),
    .iocs(iocs8), .iorw(iorw8), .ioaddr(ioaddr8), .databus(databus8),
    .rda(rda8), .tbr(tbr8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic         exp_busy, exp_iocs, exp_iorw, exp_wr, exp_err;
  logic [1:0]   exp_ioaddr;
  logic [N-1:0] exp_ack;
  logic [7:0]   exp_wd, exp_rdata;
  int           model_rr;
  logic         aborted;

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_iocs = 1'b0; exp_iorw = 1'b1; exp_ioaddr = 2'b00;
    exp_wr = 1'b0; exp_wd = 8'h00; exp_ack = '0; exp_err = 1'b0;
  endtask

  task automatic set_reset_exp();
    set_idle_exp();
    exp_rdata = 8'h00;
    model_rr  = 0;
  endtask

  // Advance one clock edge; a reset edge or reset held at a clock edge
  // cancels whatever the model was predicting.
  task automatic tick();
    @(posedge clk or posedge rst);
    aborted = rst;
    if (aborted) set_reset_exp();
  endtask

  initial begin : model
    int         w, stalls;
    logic       rw, e, ok, protect;
    logic [1:0] a;
    logic [7:0] wd;
    set_reset_exp();
    forever begin
      tick();
      if (aborted || req == '0) continue;
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(model_rr + k) % N]) w = (model_rr + k) % N;
      end
      rw = req_rw[w];
      a  = req_addr[2*w +: 2];
      wd = req_wdata[8*w +: 8];
`ifdef SPART_ARB_BAUD_PROTECT_EN
      protect = (w != 0) && !rw && a[1];
`else
      protect = 1'b0;
`endif
      exp_busy = 1'b1;
      e = 1'b0;
      if (protect) begin
        e = 1'b1;
      end else begin
        stalls = 0;
        ok = 1'b0;
        while (!ok) begin
          tick();
          if (aborted) break;
          if (a != 2'b00 || (rw ? rda : tbr)) begin
            ok = 1'b1;
          end else begin
            stalls++;
            if (STALL != 0 && stalls == STALL) begin
              e = 1'b1;
              break;
            end
          end
        end
        if (aborted) continue;
        if (ok) begin
          exp_iocs = 1'b1; exp_iorw = rw; exp_ioaddr = a;
          exp_wr = !rw; exp_wd = wd;
          tick();
          if (aborted) continue;
          if (rw) exp_rdata = spart_data;
          exp_iocs = 1'b0; exp_iorw = 1'b1; exp_ioaddr = 2'b00;
          exp_wr = 1'b0;
        end
      end
      exp_ack = '0;
      exp_ack[w] = 1'b1;
      exp_err = e;
      tick();
      if (aborted) continue;
      model_rr = (w + 1) % N;
      set_idle_exp();
    end
  end

  always @(negedge clk) begin
    chk("outputs", 32'({busy, iocs, iorw, ioaddr, ack, err, rdata}),
        32'({exp_busy, exp_iocs, exp_iorw, exp_ioaddr, exp_ack, exp_err, exp_rdata}));
    if (exp_wr) chk("databus_wr", 32'(databus), 32'(exp_wd));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [1:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    req_rw[i] = rw;
    req_addr[2*i +: 2] = a;
    req_wdata[8*i +: 8] = d;
  endtask

  task automatic wait_ack(input int budget, output int cyc, output int idx,
                          output logic e, output logic saw, output logic [7:0] bus);
    cyc = 0; idx = -1; e = 1'b0; saw = 1'b0; bus = 8'h00;
    while (idx < 0 && cyc < budget) begin
      step();
      cyc++;
      if (iocs) begin
        saw = 1'b1;
        bus = databus;
      end
      for (int i = 0; i < N; i++) if (ack[i]) idx = i;
      if (idx >= 0) e = err;
    end
    chk("ack_seen", 32'(idx >= 0), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         cyc, idx, thr;
    logic       e, saw;
    logic [7:0] bus;
    int         exp_order[4];

    rst = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    rda = 1'b1; tbr = 1'b1; spart_data = 8'h00;
    req8 = '0; req_rw8 = '0; req_addr8 = '0; req_wdata8 = '0; rda8 = 1'b0; tbr8 = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 32'({busy, iocs, iorw, ioaddr, ack, err, rdata}),
        32'({1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 8'h00}));
    rst = 1'b0;
    step();

    // requester 0 writes the baud low register
    set_req(0, 1'b0, 2'b10, 8'h16);
    step();
    chk("t1_check_no_iocs", 32'({busy, iocs}), 32'({1'b1, 1'b0}));
    step();
    chk("t1_bus", 32'({iocs, iorw, ioaddr, databus}), 32'({1'b1, 1'b0, 2'b10, 8'h16}));
    step();
    chk("t1_ack", 32'({ack, err}), 32'({2'b01, 1'b0}));
    req = '0;
    step();
    chk("t1_ack_width", 32'(ack), 32'd0);

    // requester 1 reads data while rda stays low for 20 cycles
    rda = 1'b0;
    set_req(1, 1'b1, 2'b00, 8'h00);
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (iocs) saw = 1'b1;
    end
    chk("t2_no_iocs_stall", 32'(saw), 32'd0);
    rda = 1'b1;
    spart_data = 8'h5A;
    step();
    chk("t2_read_cycle", 32'({iocs, iorw, ioaddr}), 32'({1'b1, 1'b1, 2'b00}));
    step();
    chk("t2_ack", 32'({ack, err, rdata}), 32'({2'b10, 1'b0, 8'h5A}));
    req = '0;
    step();

    // both requesters held: grants alternate
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    spart_data = 8'h3C;
    set_req(0, 1'b0, 2'b01, 8'hA1);
    set_req(1, 1'b1, 2'b01, 8'h00);
    for (int g = 0; g < 4; g++) begin
      wait_ack(10, cyc, idx, e, saw, bus);
      chk("t3_order", 32'(idx), 32'(exp_order[g]));
      chk("t3_latency", 32'(cyc), 32'd3);
      if (g == 3) req = '0;
      step();
      chk("t3_ack_width", 32'(ack), 32'd0);
    end

    // STALL_MAX=8 instance: tbr held low on a data write
    req8[0] = 1'b1; req_rw8[0] = 1'b0; req_addr8[1:0] = 2'b00; req_wdata8[7:0] = 8'h33;
    cyc = 0; saw = 1'b0;
    while (ack8 == '0 && cyc < 30) begin
      step();
      cyc++;
      if (iocs8) saw = 1'b1;
    end
    chk("t4_abort_cycles", 32'(cyc), 32'd9);
    chk("t4_abort_ack", 32'({ack8, err8, saw, rdata8}), 32'({2'b01, 1'b1, 1'b0, 8'h00}));
    req8 = '0;
    step();

    // reset while the arbiter waits in CHECK
    set_req(0, 1'b0, 2'b01, 8'h77);
    wait_ack(10, cyc, idx, e, saw, bus);
    chk("t5_pre_grant", 32'(idx), 32'd0);
    req = '0;
    step();
    rda = 1'b0;
    set_req(1, 1'b1, 2'b00, 8'h00);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_reset_now", 32'({iocs, ack, busy, err}), 32'd0);
    req = '0;
    rda = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    set_req(0, 1'b1, 2'b01, 8'h00);
    set_req(1, 1'b1, 2'b01, 8'h00);
    wait_ack(10, cyc, idx, e, saw, bus);
    chk("t5_rr_reset_winner", 32'(idx), 32'd0);
    req = '0;
    step();

    // baud register write from requester 1, then from requester 0
    set_req(1, 1'b0, 2'b11, 8'h28);
    wait_ack(10, cyc, idx, e, saw, bus);
`ifdef SPART_ARB_BAUD_PROTECT_EN
    chk("t6_req1_protected", 32'({cyc[3:0], idx[1:0], e, saw}), 32'({4'd1, 2'd1, 1'b1, 1'b0}));
`else
    chk("t6_req1_write", 32'({cyc[3:0], idx[1:0], e, saw, bus}), 32'({4'd3, 2'd1, 1'b0, 1'b1, 8'h28}));
`endif
    req = '0;
    step();
    set_req(0, 1'b0, 2'b11, 8'h28);
    wait_ack(10, cyc, idx, e, saw, bus);
    chk("t6_req0_write", 32'({cyc[3:0], idx[1:0], e, saw, bus}), 32'({4'd3, 2'd0, 1'b0, 1'b1, 8'h28}));
    req = '0;
    step();

    // randomized requesters and SPART status
    thr = 8;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c % 150 == 0) thr = $urandom_range(0, 10);
      rda = $urandom_range(0, 9) < thr;
      tbr = $urandom_range(0, 9) < thr;
      spart_data = 8'($urandom);
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
        continue;
      end
      for (int i = 0; i < N; i++) begin
        if ((req[i] && ack[i]) || !req[i]) begin
          if ((req[i] && $urandom_range(0, 2) == 0) || (!req[i] && $urandom_range(0, 3) == 0)) begin
            set_req(i, 1'($urandom), ($urandom_range(0, 1) == 1) ? 2'b00 : 2'($urandom), 8'($urandom));
          end else begin
            req[i] = 1'b0;
          end
        end
      end
    end
    req = '0;
    repeat (STALL + 6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
